// File: rtl/duck_pkg.sv
// Shared types and helpers for the light-gun shot controller.
package duck_pkg;

  // Shot sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BLACK,
    WHITE,
    RESULT,
    COOLDOWN
  } shot_state_t;

  // Frame override requested from pattern_gen.
  typedef logic [1:0] flash_mode_t;

  localparam flash_mode_t FLASH_NORMAL = 2'd0;
  localparam flash_mode_t FLASH_BLACK  = 2'd1;
  localparam flash_mode_t FLASH_TARGET = 2'd2;

  // Width of a gun index; never narrower than one bit.
  function automatic int unsigned SHOOTER_W(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gun_input_cond.sv
// One gun channel: 2-flop synchronisers on trigger and detect, trigger
// debounce, and a rising-edge pulse on the debounced trigger level.
module gun_input_cond #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic detect,
  output logic trig_rise,
  output logic detect_sync
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]      trig_sync_q;
  logic [1:0]      det_sync_q;
  logic            trig_deb_q, trig_deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise_q, rise_d;

  // Count consecutive synchronised samples that disagree with the debounced
  // level; flip the level once DEBOUNCE_CYC of them have been seen in a row.
  always_comb begin
    cnt_d      = cnt_q;
    trig_deb_d = trig_deb_q;
    rise_d     = 1'b0;
    if (trig_sync_q[1] == trig_deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
      cnt_d      = '0;
      trig_deb_d = trig_sync_q[1];
      rise_d     = trig_sync_q[1];
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Synchroniser, debounce and edge registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_sync_q <= '0;
      det_sync_q  <= '0;
      trig_deb_q  <= 1'b0;
      cnt_q       <= '0;
      rise_q      <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[0], trigger};
      det_sync_q  <= {det_sync_q[0], detect};
      trig_deb_q  <= trig_deb_d;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
    end
  end

  assign trig_rise   = rise_q;
  assign detect_sync = det_sync_q[1];

endmodule

// File: rtl/duck_shot_ctrl.sv
// Multi-player light-gun shot controller: conditions the gun pins, grants
// shots round-robin, sequences the flash frames and keeps per-player scores.
// Optional macro DUCK_AMBIENT_CHECK_EN adds a black frame before the target
// frame; light seen there marks the shot as a cheat and forces a miss.
module duck_shot_ctrl
  import duck_pkg::*;
#(
  parameter int unsigned NUM_GUNS        = 2,
  parameter int unsigned SCORE_W         = 4,
  parameter int unsigned DEBOUNCE_CYC    = 16,
  parameter int unsigned FLASH_FRAMES    = 1,
  parameter int unsigned COOLDOWN_FRAMES = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic                             valid,
  input  logic [NUM_GUNS-1:0]              trigger,
  input  logic [NUM_GUNS-1:0]              detect,
  output logic [1:0]                       flash_mode,
  output logic [SHOOTER_W(NUM_GUNS)-1:0]   shooter,
  output logic                             busy,
  output logic                             hit,
  output logic                             miss,
  output logic [NUM_GUNS*SCORE_W-1:0]      score
);

  localparam int unsigned SW      = SHOOTER_W(NUM_GUNS);
  localparam int unsigned FRM_MAX = (FLASH_FRAMES > COOLDOWN_FRAMES) ? FLASH_FRAMES
                                                                     : COOLDOWN_FRAMES;
  localparam int unsigned FW      = (FRM_MAX > 1) ? $clog2(FRM_MAX) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [NUM_GUNS-1:0] trig_rise;
  logic [NUM_GUNS-1:0] det_sync;

  for (genvar g = 0; g < NUM_GUNS; g++) begin : g_gun
    gun_input_cond #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_cond (
      .clk        (clk),
      .reset      (reset),
      .trigger    (trigger[g]),
      .detect     (detect[g]),
      .trig_rise  (trig_rise[g]),
      .detect_sync(det_sync[g])
    );
  end

  shot_state_t               state_q, state_d;
  logic [NUM_GUNS-1:0]       pending_q, pending_d;
  logic [SW-1:0]             rr_q, rr_d;
  logic [SW-1:0]             shooter_q, shooter_d;
  logic [FW-1:0]             frm_q, frm_d;
  logic                      hit_seen_q, hit_seen_d;
  logic [NUM_GUNS*SCORE_W-1:0] score_q, score_d;

`ifdef DUCK_AMBIENT_CHECK_EN
  logic cheat_q, cheat_d;

  // Ambient-light flag raised during the black frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cheat_q <= 1'b0;
    end else begin
      cheat_q <= cheat_d;
    end
  end
`else
  logic cheat_q;
  assign cheat_q = 1'b0;
`endif

  // Round-robin pick: lowest pending index at or above rr_q, else lowest overall.
  logic [SW-1:0] winner, win_hi, win_any;
  logic          found_hi;
  always_comb begin
    win_hi   = '0;
    win_any  = '0;
    found_hi = 1'b0;
    for (int i = int'(NUM_GUNS) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        win_any = SW'(i);
        if (i >= int'(rr_q)) begin
          win_hi   = SW'(i);
          found_hi = 1'b1;
        end
      end
    end
    winner = found_hi ? win_hi : win_any;
  end

  logic det_cur;
  logic verdict_hit;
  assign det_cur = det_sync[shooter_q] & valid;

  // Next-state, flash selection and verdict decode.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    rr_d        = rr_q;
    shooter_d   = shooter_q;
    frm_d       = frm_q;
    hit_seen_d  = hit_seen_q;
    score_d     = score_q;
    flash_mode  = FLASH_NORMAL;
    verdict_hit = 1'b0;
    hit         = 1'b0;
    miss        = 1'b0;
`ifdef DUCK_AMBIENT_CHECK_EN
    cheat_d     = cheat_q;
`endif
    unique case (state_q)
      IDLE: begin
        pending_d = pending_q | trig_rise;
        if (|pending_q) begin
          // Edges arriving in the grant cycle are dropped with the rest.
          shooter_d = winner;
          rr_d      = (winner == SW'(NUM_GUNS - 1)) ? '0 : winner + SW'(1);
          pending_d = '0;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (frame_start) begin
          frm_d = '0;
`ifdef DUCK_AMBIENT_CHECK_EN
          state_d = BLACK;
`else
          state_d = WHITE;
`endif
        end
      end
      BLACK: begin
        flash_mode = FLASH_BLACK;
`ifdef DUCK_AMBIENT_CHECK_EN
        if (det_cur) cheat_d = 1'b1;
`endif
        if (frame_start) state_d = WHITE;
      end
      WHITE: begin
        flash_mode = FLASH_TARGET;
        if (det_cur) hit_seen_d = 1'b1;
        if (frame_start) begin
          if (frm_q == FW'(FLASH_FRAMES - 1)) begin
            frm_d   = '0;
            state_d = RESULT;
          end else begin
            frm_d = frm_q + FW'(1);
          end
        end
      end
      RESULT: begin
        verdict_hit = hit_seen_q & ~cheat_q;
        hit         = verdict_hit;
        miss        = ~verdict_hit;
        if (verdict_hit) begin
          for (int p = 0; p < int'(NUM_GUNS); p++) begin
            if (shooter_q == SW'(p) && score_q[p*SCORE_W +: SCORE_W] != SCORE_MAX) begin
              score_d[p*SCORE_W +: SCORE_W] = score_q[p*SCORE_W +: SCORE_W] + SCORE_W'(1);
            end
          end
        end
        hit_seen_d = 1'b0;
`ifdef DUCK_AMBIENT_CHECK_EN
        cheat_d    = 1'b0;
`endif
        frm_d      = '0;
        state_d    = COOLDOWN;
      end
      COOLDOWN: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_d = IDLE;
        end else if (frame_start) begin
          if (frm_q == FW'(COOLDOWN_FRAMES - 1)) begin
            frm_d   = '0;
            state_d = IDLE;
          end else begin
            frm_d = frm_q + FW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      rr_q       <= '0;
      shooter_q  <= '0;
      frm_q      <= '0;
      hit_seen_q <= 1'b0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      shooter_q  <= shooter_d;
      frm_q      <= frm_d;
      hit_seen_q <= hit_seen_d;
      score_q    <= score_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign shooter = shooter_q;
  assign score   = score_q;

endmodule

// File: tb/tb_duck_shot_ctrl.sv
// Directed bench for duck_shot_ctrl with a verdict scoreboard.
// Honours DUCK_AMBIENT_CHECK_EN when the design is built with it.
module tb_duck_shot_ctrl;
  import duck_pkg::*;

`ifdef DUCK_AMBIENT_CHECK_EN
  localparam bit AMB = 1'b1;
`else
  localparam bit AMB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] trigger = 2'b00;
  logic [1:0] detect = 2'b00;
  logic [1:0] flash_mode;
  logic [0:0] shooter;
  logic       busy, hit, miss;
  logic [7:0] score;

  duck_shot_ctrl #(
    .NUM_GUNS       (2),
    .SCORE_W        (4),
    .DEBOUNCE_CYC   (16),
    .FLASH_FRAMES   (1),
    .COOLDOWN_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .valid      (valid),
    .trigger    (trigger),
    .detect     (detect),
    .flash_mode (flash_mode),
    .shooter    (shooter),
    .busy       (busy),
    .hit        (hit),
    .miss       (miss),
    .score      (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] hm;
    logic       sh;
    logic [7:0] sc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_score[2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Verdict monitor: pops the scoreboard on each hit/miss pulse, then checks
  // the score and that the pulse lasted one cycle.
  logic       post_chk = 1'b0;
  logic [7:0] post_sc;
  always @(negedge clk) begin
    exp_t e;
    if (post_chk) begin
      post_chk = 1'b0;
      check("score_after_verdict", {24'd0, score}, {24'd0, post_sc});
      check("verdict_one_cycle", {30'd0, hit, miss}, 32'd0);
    end
    if (hit || miss) begin
      if (sb.size() == 0) begin
        check("unexpected_verdict", {30'd0, hit, miss}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("verdict_hit_miss", {30'd0, hit, miss}, {30'd0, e.hm});
        check("verdict_shooter", {31'd0, shooter}, {31'd0, e.sh});
        post_sc  = e.sc;
        post_chk = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] m);
    trigger = m;
    tick(20);
    trigger = 2'b00;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 60) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd1);
  endtask

  // 12-cycle frame body: valid high on cycles 4..7; din lights the
  // photodiode around the valid window, dout only well outside it.
  task automatic body(input logic [1:0] din, input logic [1:0] dout);
    for (int c = 0; c < 12; c++) begin
      valid  = (c >= 4 && c < 8);
      detect = ((c >= 2 && c < 10) ? din : 2'b00) | ((c < 2 || c >= 10) ? dout : 2'b00);
      tick(1);
    end
    valid  = 1'b0;
    detect = 2'b00;
  endtask

  task automatic frame(input string tag, input logic [1:0] exp_flash, input logic [1:0] din,
                       input logic [1:0] dout);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check(tag, {30'd0, flash_mode}, {30'd0, exp_flash});
    body(din, dout);
  endtask

  task automatic shot(input string tag, input logic [1:0] trig, input logic exp_sh,
                      input logic [1:0] black_det, input logic [1:0] white_in,
                      input logic [1:0] white_out);
    exp_t e;
    logic exp_hit;
    press(trig);
    wait_busy({tag, "_busy"});
    check({tag, "_shooter"}, {31'd0, shooter}, {31'd0, exp_sh});
    check({tag, "_arm_flash"}, {30'd0, flash_mode}, {30'd0, FLASH_NORMAL});
    body(black_det, 2'b00);
`ifdef DUCK_AMBIENT_CHECK_EN
    frame({tag, "_black_flash"}, FLASH_BLACK, black_det, 2'b00);
`endif
    frame({tag, "_white_flash"}, FLASH_TARGET, white_in, white_out);
    exp_hit = white_in[exp_sh] && !(AMB && black_det[exp_sh]);
    if (exp_hit && model_score[exp_sh] < 15) model_score[exp_sh]++;
    e.hm = exp_hit ? 2'b10 : 2'b01;
    e.sh = exp_sh;
    e.sc = {model_score[1][3:0], model_score[0][3:0]};
    sb.push_back(e);
    frame({tag, "_result_flash"}, FLASH_NORMAL, 2'b00, 2'b00);
    check({tag, "_cool_busy"}, {31'd0, busy}, 32'd1);
    frame({tag, "_cool1_flash"}, FLASH_NORMAL, 2'b00, 2'b00);
    check({tag, "_cool1_busy"}, {31'd0, busy}, 32'd1);
    frame({tag, "_cool2_flash"}, FLASH_NORMAL, 2'b00, 2'b00);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int busy_seen;
    tick(1);
    reset = 1'b0;
    tick(3);
    check("reset_flash", {30'd0, flash_mode}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_score", {24'd0, score}, 32'd0);
    check("reset_shooter", {31'd0, shooter}, 32'd0);
    check("reset_verdict", {30'd0, hit, miss}, 32'd0);
    reset = 1'b1;
    tick(2);

    // Short trigger glitch must never reach pending.
    trigger   = 2'b01;
    tick(5);
    trigger   = 2'b00;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_seen = 1;
      tick(1);
    end
    check("glitch_busy", busy_seen, 0);
    frame("glitch_idle_flash", FLASH_NORMAL, 2'b00, 2'b00);

    shot("g0_hit", 2'b01, 1'b0, 2'b00, 2'b01, 2'b00);
    shot("g1_ambient", 2'b10, 1'b1, 2'b10, 2'b10, 2'b00);
    shot("pair_a", 2'b11, 1'b0, 2'b00, 2'b01, 2'b00);
    shot("pair_b", 2'b11, 1'b1, 2'b00, 2'b00, 2'b00);
    shot("g0_outside_valid", 2'b01, 1'b0, 2'b00, 2'b00, 2'b01);
    repeat (13) shot("g0_fill", 2'b01, 1'b0, 2'b00, 2'b01, 2'b00);
    shot("g0_saturate", 2'b01, 1'b0, 2'b00, 2'b01, 2'b00);

    // Reset in the middle of the white frame.
    press(2'b10);
    wait_busy("rst_busy");
    check("rst_shooter", {31'd0, shooter}, 32'd1);
    body(2'b00, 2'b00);
`ifdef DUCK_AMBIENT_CHECK_EN
    frame("rst_black_flash", FLASH_BLACK, 2'b00, 2'b00);
`endif
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("rst_white_flash", {30'd0, flash_mode}, {30'd0, FLASH_TARGET});
    detect = 2'b10;
    valid  = 1'b1;
    tick(3);
    reset = 1'b0;
    #1;
    check("rst_now_flash", {30'd0, flash_mode}, 32'd0);
    check("rst_now_score", {24'd0, score}, 32'd0);
    check("rst_now_busy", {31'd0, busy}, 32'd0);
    detect = 2'b00;
    valid  = 1'b0;
    model_score[0] = 0;
    model_score[1] = 0;
    tick(2);
    reset = 1'b1;
    tick(2);
    check("rst_sb_empty", sb.size(), 0);
    shot("post_rst", 2'b10, 1'b1, 2'b00, 2'b10, 2'b00);

    tick(4);
    check("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/duck_shot_ctrl.md
Name: duck_shot_ctrl

Overview:
- Multi-player light-gun shot controller for the Duck Hunt VGA pipeline; sits between the raw gun pins and pattern_gen, fed by the vga timing block.
- Synchronises and debounces N trigger/detect pairs and arbitrates shots round-robin.
- Sequences black-frame / target-frame flashes via flash_mode, judges hit or miss, and keeps a saturating score per player.

Parameters:
- NUM_GUNS, 2, number of gun channels (1..8)
- SCORE_W, 4, score width per player
- DEBOUNCE_CYC, 16, stable-cycle count required on the synchronised trigger before an edge is accepted
- FLASH_FRAMES, 1, number of target (white) frames per shot
- COOLDOWN_FRAMES, 2, normal frames after a verdict before the next shot is accepted

Ports:
- clk  in  1  pixel clock from the PLL
- reset  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame (vga vsync edge)
- valid  in  1  active-video region qualifier
- trigger  in  NUM_GUNS  raw trigger pins, asynchronous
- detect  in  NUM_GUNS  raw photodiode pins, asynchronous
- flash_mode  out  2  0 = normal scene, 1 = all-black, 2 = black with white target, 3 = reserved
- shooter  out  max(1,$clog2(NUM_GUNS))  index of the gun under evaluation
- busy  out  1  high whenever state is not IDLE
- hit  out  1  one-cycle verdict pulse
- miss  out  1  one-cycle verdict pulse
- score  out  NUM_GUNS*SCORE_W  packed scores; player i occupies bits [i*SCORE_W +: SCORE_W]

Behaviour:
- Reset (async, reset = 0): state IDLE; flash_mode, shooter, busy, hit, miss, score, pending and the round-robin pointer all 0; synchronisers and debounce counters cleared. A reset mid-shot aborts at once and flash_mode returns to 0 in the same cycle.
- Input conditioning:
  - trigger and detect each pass through a 2-flop synchroniser.
  - The debounced trigger level changes only after DEBOUNCE_CYC consecutive equal synchronised samples.
  - A rising edge of the debounced level sets pending[i], but only while state is IDLE; edges seen in any other state are dropped.
- IDLE:
  - If any pending bit is set, the winner is the first set bit at or after rr_ptr, wrapping modulo NUM_GUNS.
  - shooter <= winner; rr_ptr <= winner+1 (mod NUM_GUNS); all pending bits cleared; next state ARM.
- ARM:
  - flash_mode = 0; wait for frame_start.
  - A frame_start in the same cycle as the IDLE->ARM transition does not count; the next frame_start is used.
  - On frame_start go to BLACK (or WHITE, see Optional Feature).
- BLACK: flash_mode = 1 for one full frame. Synchronised detect[shooter] high while valid sets the cheat flag. The next frame_start goes to WHITE.
- WHITE:
  - flash_mode = 2 for FLASH_FRAMES frames, counted by frame_start pulses.
  - detect[shooter] high while valid sets hit_seen.
  - The frame_start that ends the last white frame goes to RESULT.
- RESULT (exactly one cycle):
  - hit = hit_seen & ~cheat; miss = ~hit.
  - On hit, score[shooter] increments, saturating at 2^SCORE_W-1.
  - Then COOLDOWN; hit_seen and cheat are cleared.
- COOLDOWN: flash_mode = 0 for COOLDOWN_FRAMES frame_start pulses, then IDLE.
- Latency: the hit/miss pulse comes 1 cycle after the frame_start that ends the final white frame.
- detect outside valid is ignored in every state.
- frame_start arriving while valid is high is treated normally; valid only gates detect sampling.

Optional Feature:
- Macro: DUCK_AMBIENT_CHECK_EN.
- Defined: BLACK state present; light seen during the black frame (TV/lamp aiming) forces miss.
- Undefined: ARM goes directly to WHITE on frame_start; the cheat flag is tied to 0. Verdict latency is one frame shorter.

Decomposition:
- Package duck_pkg:
  - shot_state_t enum {IDLE, ARM, BLACK, WHITE, RESULT, COOLDOWN};
  - flash_mode_t with constants FLASH_NORMAL=0, FLASH_BLACK=1, FLASH_TARGET=2;
  - SHOOTER_W function.
- Sub-module gun_input_cond: one channel containing both synchronisers, the debounce counter and the edge detector. It is instantiated NUM_GUNS times in a generate loop.

Test Plan:
- Trigger 0 held high for 20 cycles; detect 0 high during valid only in the white frame -> flash_mode sequence 0,1,2,0; hit pulse 1 cycle after the white frame ends; score[0] = 1.
- Trigger 1 with detect 1 high in both the black and white frames (feature on) -> miss = 1, score[1] unchanged; feature off -> hit = 1.
- Triggers 0 and 1 rise in the same cycle, rr_ptr = 0 -> shooter = 0 served; the trigger-1 edge is dropped; next simultaneous pair -> shooter = 1.
- Trigger glitch 5 cycles wide (DEBOUNCE_CYC = 16) -> no pending; busy stays 0.
- score[0] = 15 with SCORE_W = 4, then another hit -> stays 15, hit still pulses.
- reset asserted during WHITE -> flash_mode = 0 and score = 0 immediately; after reset releases, a new trigger starts a fresh shot from ARM.
